// File: rtl/csa_resolver.sv
// csa_resolver: sequential carry-propagate resolver for carry-save operands.
// Resolves sum + 2*carry + cin over NCH cycles using one CHUNK-bit adder
// and a carry flop, trading latency for area after a compressor tree.
module csa_resolver #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_value,
  output logic             busy
);

  // Result width, number of resolve cycles and chunk-padded operand width.
  localparam int OW  = WIDTH + 2;
  localparam int NCH = (OW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = $clog2(PW + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [PW-1:0]  a_r;
  logic [PW-1:0]  b_r;
  logic           carry_r;
  logic [KW-1:0]  k_r;
  logic [OW-1:0]  res_r;
  logic           out_valid_r;
  logic           busy_r;
  logic           in_ready_r;
  logic [SW-1:0]  shamt_s;
  logic [CHUNK:0] chunk_s;

  // Narrow adder: one chunk of A plus one chunk of B plus the running carry.
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Bit offset of the chunk under resolution and its chunk sum with carry-out.
  always_comb begin
    shamt_s = SW'(k_r) * SW'(CHUNK);
    chunk_s = chunk_add(CHUNK'(a_r >> shamt_s), CHUNK'(b_r >> shamt_s), carry_r);
  end

  // Handshake control, operand capture and chunk-by-chunk resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      k_r         <= '0;
      res_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= PW'(in_sum);
            b_r        <= PW'({in_carry, 1'b0});
            carry_r    <= in_cin;
            k_r        <= '0;
            res_r      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          // Bits beyond WIDTH+2 of the last chunk fall off in the truncation.
          res_r   <= res_r | OW'(PW'(chunk_s[CHUNK-1:0]) << shamt_s);
          carry_r <= chunk_s[CHUNK];
          if (k_r == K_LAST) begin
            k_r         <= '0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is held low for as long as reset is asserted.
  assign in_ready  = in_ready_r & rst_n;
  assign out_valid = out_valid_r;
  assign out_value = res_r;
  assign busy      = busy_r;

endmodule
